// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request and register-file write-back bundle for muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic [ADDR_W-1:0] rd_in;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;

  modport master (
    output start, op, a_in, b_in, rd_in,
    input  busy, done, div_by_zero, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  start, op, a_in, b_in, rd_in,
    output busy, done, div_by_zero, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide unit, fixed WIDTH+1 cycle latency
module muldiv_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic              dz_flag_q, dz_flag_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]  wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ok;

  // hi/lo double as product {hi,lo} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    dz_flag_d = dz_flag_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_we_d   = 1'b0;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          cnt_d     = '0;
          op_d      = bus.op;
          hi_d      = '0;
          lo_d      = bus.op[1] ? bus.a_in : bus.b_in;
          opnd_d    = bus.op[1] ? bus.b_in : bus.a_in;
          dz_flag_d = bus.op[1] && (bus.b_in == '0);
          wb_addr_d = bus.rd_in;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ok};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d   = WB;
          wb_we_d   = 1'b1;
          done_d    = 1'b1;
          dz_d      = dz_flag_q;
          // op[0] picks the upper half (MULH/REMU) over the lower half (MUL/DIVU)
          wb_data_d = op_q[0] ? hi_d : lo_d;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      dz_flag_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      dz_flag_q <= dz_flag_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  muldiv_unit_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  muldiv_unit #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
      default: return (b == 16'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op; during the run the inputs are scrambled and, if noisy, start is pulsed randomly.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] rd, input bit noisy);
    int we_cnt;
    int we_at;
    int busy_err;
    int done_err;
    logic [15:0] got_data;
    logic [3:0]  got_addr;
    logic        got_dz;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.rd_in = rd;
    @(posedge clk);
    we_cnt = 0; we_at = -1; busy_err = 0; done_err = 0;
    got_data = '0; got_addr = '0; got_dz = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.op    = 2'($urandom);
      bus.a_in  = 16'($urandom);
      bus.b_in  = 16'($urandom);
      bus.rd_in = 4'($urandom);
      if (noisy && (k == 8 || k == 17)) bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (bus.busy !== (k <= 16)) busy_err++;
      if (bus.done !== bus.wb_we) done_err++;
      if (bus.wb_we === 1'b1) begin
        we_cnt++;
        we_at    = k;
        got_data = bus.wb_data;
        got_addr = bus.wb_addr;
        got_dz   = bus.div_by_zero;
      end else if (bus.div_by_zero !== 1'b0) begin
        done_err++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " we_count"}, we_cnt, 1);
    check({tag, " latency"}, we_at, 16);
    check({tag, " busy_profile"}, busy_err, 0);
    check({tag, " done_align"}, done_err, 0);
    check({tag, " wb_addr"}, got_addr, rd);
    check({tag, " wb_data"}, got_data, model(op, a, b));
    check({tag, " div_by_zero"}, got_dz, (op[1] && b == 16'd0));
  endtask

  initial begin
    int we_seen;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset wb_we", bus.wb_we, 0);
    check("reset dz", bus.div_by_zero, 0);
    check("reset wb_addr", bus.wb_addr, 0);
    check("reset wb_data", bus.wb_data, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_3x5",      2'd0, 16'd3,     16'd5,     4'd2, 1'b0);
    run_op("mul_ffff",     2'd0, 16'hFFFF,  16'hFFFF,  4'd7, 1'b0);
    run_op("mulh_ffff",    2'd1, 16'hFFFF,  16'hFFFF,  4'd7, 1'b0);
    run_op("divu_100_7",   2'd2, 16'd100,   16'd7,     4'd3, 1'b0);
    run_op("remu_100_7",   2'd3, 16'd100,   16'd7,     4'd3, 1'b0);
    run_op("divu_by0",     2'd2, 16'h1234,  16'd0,     4'd4, 1'b0);
    run_op("remu_by0",     2'd3, 16'h1234,  16'd0,     4'd4, 1'b0);
    run_op("mulh_b0",      2'd1, 16'h8000,  16'd0,     4'd0, 1'b0);
    run_op("mul_ignore",   2'd0, 16'd2,     16'd2,     4'd1, 1'b1);
    run_op("mul_b2b",      2'd0, 16'd9,     16'd9,     4'd5, 1'b0);

    // Abort a DIVU mid-run and make sure it never writes back.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a_in = 16'd50; bus.b_in = 16'd5; bus.rd_in = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", bus.busy, 0);
    check("abort wb_we", bus.wb_we, 0);
    check("abort wb_data", bus.wb_data, 0);
    @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wb_we === 1'b1 || bus.busy === 1'b1) we_seen++;
    end
    check("abort no_wb", we_seen, 0);
    run_op("divu_after_abort", 2'd2, 16'd50, 16'd5, 4'd6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [1:0]  rop;
      rop = 2'($urandom);
      ra  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'd0;
        1:       rb = 16'hFFFF;
        2:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
